// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions and the ID/EX bundle.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    localparam logic ST_ISSUE = 1'b0;
    localparam logic ST_STALL = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   instr;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
        logic              valid;
    } ex_bundle_t;

    // Returns {uses_rs2, uses_rs1}; unknown opcodes are treated as reading rs1 only.
    function automatic logic [1:0] src_use(input logic [6:0] opc);
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL:      src_use = 2'b00;
            OP_OP, OP_STORE, OP_BRANCH:    src_use = 2'b11;
            OP_JALR, OP_IMM, OP_LOAD:      src_use = 2'b01;
            default:                       src_use = 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/id_issue_stage_operand_fwd.sv
// Priority forwarding mux for one EX operand: x0, EX/MEM, writeback, same-edge bypass, regfile.
module operand_fwd
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_byp_v,
    input  logic [XLEN-1:0]   i_byp_d,
    input  logic [XLEN-1:0]   i_rf_data,
    output logic [XLEN-1:0]   o_data
);

    always_comb begin
        o_data = i_rf_data;
        if (i_src == '0)
            o_data = '0;
        else if (i_mem_we && (i_mem_rd == i_src))
            o_data = i_mem_data;
        else if (i_wb_we && (i_wb_rd == i_src))
            o_data = i_wb_data;
        else if (i_byp_v)
            o_data = i_byp_d;
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: drives regfile addresses, holds the ID/EX register, forwards
// operands and inserts a single-cycle bubble on load-use hazards.
module id_issue_stage
    import pipe_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_instr,
    input  logic [XLEN-1:0]   i_id_pc,
    output logic              o_id_ready,
    input  logic              i_flush,
    output logic [REG_AW-1:0] o_addr1,
    output logic [REG_AW-1:0] o_addr2,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_instr,
    output logic [REG_AW-1:0] o_ex_rd,
    output logic              o_ex_we,
    output logic              o_ex_is_load,
    output logic [XLEN-1:0]   o_ex_op_a,
    output logic [XLEN-1:0]   o_ex_op_b
);

    logic [6:0]        w_opcode;
    logic [1:0]        w_use;
    logic              w_haz;
    logic              w_stall;
    logic              w_state_next;
    logic              r_state;
    ex_bundle_t        w_ex_next;
    ex_bundle_t        r_ex;
    logic [REG_AW-1:0] w_addr [2];
    logic [REG_AW-1:0] w_src  [2];
    logic [XLEN-1:0]   w_rf   [2];
    logic [XLEN-1:0]   w_op   [2];
    logic              r_byp_v [2];
    logic [XLEN-1:0]   r_byp_d [2];

    assign w_opcode  = i_id_instr[OPC_MSB:OPC_LSB];
    assign w_use     = src_use(w_opcode);
    assign w_addr[0] = i_id_instr[RS1_MSB:RS1_LSB];
    assign w_addr[1] = i_id_instr[RS2_MSB:RS2_LSB];
    assign w_src[0]  = r_ex.instr[RS1_MSB:RS1_LSB];
    assign w_src[1]  = r_ex.instr[RS2_MSB:RS2_LSB];
    assign w_rf[0]   = i_rs1;
    assign w_rf[1]   = i_rs2;
    assign o_addr1   = w_addr[0];
    assign o_addr2   = w_addr[1];

    assign w_haz = i_id_valid && r_ex.valid && r_ex.is_load && r_ex.we &&
                   ((w_use[0] && (r_ex.rd == w_addr[0])) ||
                    (w_use[1] && (r_ex.rd == w_addr[1])));
    assign w_stall    = w_haz && !i_flush;
    assign o_id_ready = !w_stall;

    // The bubble that follows a stall can never itself cause a hazard, so STALL always returns.
    assign w_state_next = (r_state == ST_ISSUE && w_stall) ? ST_STALL : ST_ISSUE;

    always_comb begin
        w_ex_next.pc      = i_id_pc;
        w_ex_next.instr   = i_id_instr;
        w_ex_next.rd      = i_id_instr[RD_MSB:RD_LSB];
        w_ex_next.valid   = i_id_valid;
        w_ex_next.is_load = i_id_valid && (w_opcode == OP_LOAD);
        w_ex_next.we      = i_id_valid && (i_id_instr[RD_MSB:RD_LSB] != '0) &&
                            (w_opcode != OP_STORE) && (w_opcode != OP_BRANCH);
        if (i_flush || w_stall) begin
            w_ex_next.valid   = 1'b0;
            w_ex_next.we      = 1'b0;
            w_ex_next.is_load = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ex    <= '0;
            r_state <= ST_ISSUE;
            for (int i = 0; i < 2; i++) begin
                r_byp_v[i] <= 1'b0;
                r_byp_d[i] <= '0;
            end
        end else begin
            r_ex    <= w_ex_next;
            r_state <= w_state_next;
            // The regfile returns the pre-write value on a same-edge write, so remember the write.
            for (int i = 0; i < 2; i++) begin
                r_byp_v[i] <= i_wb_we && (i_wb_rd != '0) && (i_wb_rd == w_addr[i]);
                r_byp_d[i] <= i_wb_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            operand_fwd u_fwd (
                .i_src      (w_src[gi]),
                .i_mem_we   (i_mem_we),
                .i_mem_rd   (i_mem_rd),
                .i_mem_data (i_mem_data),
                .i_wb_we    (i_wb_we),
                .i_wb_rd    (i_wb_rd),
                .i_wb_data  (i_wb_data),
                .i_byp_v    (r_byp_v[gi]),
                .i_byp_d    (r_byp_d[gi]),
                .i_rf_data  (w_rf[gi]),
                .o_data     (w_op[gi])
            );
        end
    endgenerate

    assign o_ex_valid   = r_ex.valid;
    assign o_ex_pc      = r_ex.pc;
    assign o_ex_instr   = r_ex.instr;
    assign o_ex_rd      = r_ex.rd;
    assign o_ex_we      = r_ex.we;
    assign o_ex_is_load = r_ex.is_load;
    assign o_ex_op_a    = w_op[0];
    assign o_ex_op_b    = w_op[1];

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage of the 5-stage pipeline. Sits between the IF/ID register and EX, and drives the register-file read addresses.
- The register file registers its reads, so operand data arrives one cycle after the address. This block aligns that data with its own ID/EX register.
- Adds MEM/WB forwarding, a same-edge writeback bypass, load-use stall generation and flush handling.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_instr  in  XLEN  instruction from IF/ID
id_pc  in  XLEN  PC from IF/ID
id_ready  out  1  low = stall; fetch must hold IF/ID
flush  in  1  branch/jump redirect from EX
addr1  out  REG_AW  register-file read address A = id_instr[19:15]
addr2  out  REG_AW  register-file read address B = id_instr[24:20]
rs1  in  XLEN  register-file read data A (valid one cycle after addr1)
rs2  in  XLEN  register-file read data B
mem_we, mem_rd, mem_data  in  1/REG_AW/XLEN  EX/MEM register: writes rd, dest, ALU result
wb_we, wb_rd, wb_data  in  1/REG_AW/XLEN  writeback port, shared with the register-file write
ex_valid  out  1  ID/EX holds a real instruction
ex_pc, ex_instr  out  XLEN  registered copies
ex_rd  out  REG_AW  destination index
ex_we  out  1  instruction writes rd (rd!=0, not STORE/BRANCH)
ex_is_load  out  1  opcode is LOAD
ex_op_a, ex_op_b  out  XLEN  forwarded operands, combinational from the ID/EX register

Behaviour:
- Interface: one clock Clock; reset Reset is asynchronous and active-high.
- Reset values: ex_valid=0, all ex_* registers=0, bypass flags=0, FSM=ISSUE. id_ready=1 while Reset is held.
- addr1/addr2 are driven combinationally from id_instr every cycle, including during a stall.
- Source usage:
  - uses_rs1 is false for LUI, AUIPC and JAL.
  - uses_rs2 is true only for OP (R-type), STORE and BRANCH.
- Load-use hazard: haz = id_valid & ex_valid & ex_is_load & ex_we & ((uses_rs1 & ex_rd==addr1) | (uses_rs2 & ex_rd==addr2)).
- id_ready = !(haz & !flush).
- FSM has two states, ISSUE and STALL:
  - ISSUE -> STALL on haz & !flush. On that edge ID/EX loads a bubble (ex_valid=0, ex_we=0, ex_is_load=0) and IF/ID is held.
  - STALL -> ISSUE unconditionally. The bubble cannot create a hazard, so a stall never lasts more than 1 cycle.
- Flush has priority over everything: next ex_valid=0, FSM=ISSUE, id_ready=1, and the ID instruction is dropped.
- Normal issue: ex_valid<=id_valid; ex_pc, ex_instr, ex_rd, ex_we and ex_is_load are captured. Operand latency is 1 cycle from addr to ex_op_*.
- Same-edge bypass: the register file returns the OLD value when it is written on the same edge it reads.
  - On every edge, byp1_v <= wb_we & wb_rd!=0 & wb_rd==addr1, and byp1_d <= wb_data.
  - byp2 works the same way against addr2.
- Operand mux for ex_op_a, first match wins (src = ex_instr[19:15]):
  1. src==0 -> 0
  2. mem_we & mem_rd==src -> mem_data
  3. wb_we & wb_rd==src -> wb_data
  4. byp1_v -> byp1_d
  5. otherwise -> rs1
- ex_op_b uses the same mux with ex_instr[24:20], byp2 and rs2.
- Register x0 is never forwarded.
- Reset asserted mid-stall: all state clears immediately. After Reset deasserts, the held IF/ID instruction re-issues normally.

Decomposition:
- Package pipe_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM
  - instruction field slice constants
  - typedef ex_bundle_t packing pc, instr, rd, we, is_load, valid
- Sub-module operand_fwd: the 5-level priority mux for one operand, instantiated twice (A and B).

Test Plan:
1. Reset while ex_valid=1 and FSM=STALL -> all ex_* outputs read 0 immediately, id_ready=1, no issue until Reset drops.
2. x5 holds 0x11111111. WB writes x5=0xDEADBEEF in the same cycle that `add x7,x5,x0` sits in ID -> next cycle ex_op_a=0xDEADBEEF.
3. mem_rd=6/mem_data=0xA and wb_rd=6/wb_data=0xB, both enabled, while `sub x1,x6,x6` is in EX -> ex_op_a=ex_op_b=0xA.
4. `lw x6,0(x2)` then `add x7,x6,x3` -> id_ready=0 for exactly 1 cycle, then ex_valid=0 bubble, then the add issues with the FSM back in ISSUE.
5. Load-use hazard and flush in the same cycle -> id_ready=1, next ex_valid=0, no STALL entry.
6. mem_we=1, mem_rd=0, mem_data=0xFFFFFFFF, with `addi x1,x0,4` in EX -> ex_op_a=0.
